// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle.
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int W = WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t         state;
    state_t         state_next;
    logic [CNT_W-1:0] cnt;
    logic [2*W-1:0] acc;
    logic [W-1:0]   opd;
    logic           is_div;
    logic           neg_q;
    logic           neg_r;
    logic           div_zero;

    logic           accept;
    logic           op_md;
    logic           sgn;
    logic           a_neg;
    logic           b_neg;
    logic [W-1:0]   a_mag;
    logic [W-1:0]   b_mag;
    logic [W:0]     mul_sum;
    logic [W:0]     rem_sh;
    logic [W:0]     diff;
    logic [2*W-1:0] prod;
    logic [W-1:0]   quo;
    logic [W-1:0]   rem;
    logic [W-1:0]   res_hi;
    logic [W-1:0]   res_lo;
    logic           finish;

    assign ready  = (state == IDLE);
    assign busy   = (state != IDLE);
    assign accept = start && !flush && (state == IDLE);
    assign op_md  = !op[2];
    assign sgn    = op[0];
    assign a_neg  = sgn && a[W-1];
    assign b_neg  = sgn && b[W-1];
    assign a_mag  = a_neg ? (~a + 1'b1) : a;
    assign b_mag  = b_neg ? (~b + 1'b1) : b;
    assign finish = (state == FIX) && !flush;

    // Multiply: acc holds {partial product, remaining multiplier bits}.
    assign mul_sum = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opd} : '0);
    // Divide: acc holds {partial remainder, dividend/quotient bits}.
    assign rem_sh  = {acc[2*W-1:W], acc[W-1]};
    assign diff    = rem_sh - {1'b0, opd};

    always_comb begin
        prod   = neg_q ? (~acc + 1'b1) : acc;
        quo    = neg_q ? (~acc[W-1:0] + 1'b1) : acc[W-1:0];
        rem    = neg_r ? (~acc[2*W-1:W] + 1'b1) : acc[2*W-1:W];
        res_hi = prod[2*W-1:W];
        res_lo = prod[W-1:0];
        if (is_div) begin
            res_hi = rem;
            res_lo = div_zero ? '1 : quo;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (accept && op_md) state_next = RUN;
            RUN: begin
                if (flush)          state_next = IDLE;
                else if (cnt == '0) state_next = FIX;
            end
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            acc      <= '0;
            opd      <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
        end else begin
            done <= finish;
            if (accept && op_md) begin
                cnt      <= CNT_W'(W);
                is_div   <= op[1];
                neg_q    <= a_neg ^ b_neg;
                neg_r    <= a_neg;
                div_zero <= op[1] && (b == '0);
                if (op[1]) begin
                    acc <= {{W{1'b0}}, a_mag};
                    opd <= b_mag;
                end else begin
                    acc <= {{W{1'b0}}, b_mag};
                    opd <= a_mag;
                end
            end else if (accept && op == 3'b100) begin
                hi <= a;
            end else if (accept && op == 3'b101) begin
                lo <= a;
            end
            if (state == RUN && cnt != '0) begin
                cnt <= cnt - 1'b1;
                if (!is_div)
                    acc <= {mul_sum, acc[W-1:1]};
                else if (!diff[W])
                    acc <= {diff[W-1:0], acc[W-2:0], 1'b1};
                else
                    acc <= {rem_sh[W-1:0], acc[W-2:0], 1'b0};
            end
            if (finish) begin
                hi <= res_hi;
                lo <= res_lo;
            end
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: vector table plus flush,
// mid-op start and reset-abort sequences.
module tb_mult_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         flush;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    always #5 clk = ~clk;

    mult_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .ready(ready), .busy(busy), .done(done),
        .hi(hi), .lo(lo)
    );

    typedef struct {
        string        name;
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } vec_t;

    vec_t vecs[12];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   done_cnt = 0;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int n, output bit seen);
        n = 0;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) n++;
            @(negedge clk);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        bit seen;
        issue(v.op, v.a, v.b);
        wait_done(n, seen);
        check({v.name, " done"}, 64'(seen), 64'd1);
        check({v.name, " busy_cycles"}, 64'(n), 64'(W + 2));
        check({v.name, " hi"}, 64'(hi), 64'(v.hi));
        check({v.name, " lo"}, 64'(lo), 64'(v.lo));
        @(negedge clk);
        check({v.name, " done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        int  n;
        bit  seen;
        int  dc;

        vecs[0]  = '{"multu_max", 3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                     32'hFFFFFFFE, 32'h00000001};
        vecs[1]  = '{"mult_neg", 3'b001, 32'hFFFFFFFD, 32'd7,
                     32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[2]  = '{"div_neg", 3'b011, 32'hFFFFFFF9, 32'd2,
                     32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{"divu_zero", 3'b010, 32'd100, 32'd0,
                     32'd100, 32'hFFFFFFFF};
        vecs[4]  = '{"div_ovf", 3'b011, 32'h80000000, 32'hFFFFFFFF,
                     32'h0, 32'h80000000};
        vecs[5]  = '{"divu_50_7", 3'b010, 32'd50, 32'd7,
                     32'd1, 32'd7};
        vecs[6]  = '{"div_pos_neg", 3'b011, 32'd7, 32'hFFFFFFFE,
                     32'd1, 32'hFFFFFFFD};
        vecs[7]  = '{"mult_min_sq", 3'b001, 32'h80000000, 32'h80000000,
                     32'h40000000, 32'h0};
        vecs[8]  = '{"div_zero_neg", 3'b011, 32'hFFFFFFFB, 32'd0,
                     32'hFFFFFFFB, 32'hFFFFFFFF};
        vecs[9]  = '{"mult_m1_m1", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF,
                     32'h0, 32'h1};
        vecs[10] = '{"multu_shift", 3'b000, 32'h12345678, 32'h10,
                     32'h1, 32'h23456780};
        vecs[11] = '{"multu_6_7", 3'b000, 32'd6, 32'd7,
                     32'h0, 32'd42};

        rst = 1'b1; start = 1'b0; flush = 1'b0;
        op = 3'b000; a = '0; b = '0;
        repeat (2) @(negedge clk);
        check("rst ready", 64'(ready), 64'd1);
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst hi", 64'(hi), 64'd0);
        check("rst lo", 64'(lo), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) run_vec(vecs[i]);

        // MTHI / MTLO: single-cycle, no busy, no done
        dc = done_cnt;
        issue(3'b100, 32'h12345678, 32'h0);
        check("mthi hi", 64'(hi), 64'h12345678);
        check("mthi busy", 64'(busy), 64'd0);
        issue(3'b101, 32'h9ABCDEF0, 32'h0);
        check("mtlo lo", 64'(lo), 64'h9ABCDEF0);
        check("mtlo hi_kept", 64'(hi), 64'h12345678);
        check("mtlo busy", 64'(busy), 64'd0);
        check("mt no_done", 64'(done_cnt), 64'(dc));

        // reserved op is ignored
        issue(3'b110, 32'hDEADBEEF, 32'h1);
        check("rsvd busy", 64'(busy), 64'd0);
        check("rsvd hi", 64'(hi), 64'h12345678);
        check("rsvd lo", 64'(lo), 64'h9ABCDEF0);

        // flush and start in the same idle cycle: flush wins
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = 3'b000; a = 32'd3; b = 32'd3;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("flush_start busy", 64'(busy), 64'd0);

        // flush mid-op with an ignored second start
        issue(3'b100, 32'hAAAA5555, 32'h0);
        issue(3'b101, 32'h5555AAAA, 32'h0);
        dc = done_cnt;
        issue(3'b010, 32'd50, 32'd7);
        repeat (4) @(negedge clk);
        start = 1'b1; op = 3'b000; a = 32'd3; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        check("flush pre busy", 64'(busy), 64'd1);
        repeat (3) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush busy", 64'(busy), 64'd0);
        check("flush ready", 64'(ready), 64'd1);
        repeat (40) @(negedge clk);
        check("flush no_done", 64'(done_cnt), 64'(dc));
        check("flush hi", 64'(hi), 64'hAAAA5555);
        check("flush lo", 64'(lo), 64'h5555AAAA);

        // second start mid-op ignored, original result arrives
        issue(3'b010, 32'd50, 32'd7);
        repeat (5) @(negedge clk);
        start = 1'b1; op = 3'b000; a = 32'd3; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        wait_done(n, seen);
        check("midstart done", 64'(seen), 64'd1);
        check("midstart hi", 64'(hi), 64'd1);
        check("midstart lo", 64'(lo), 64'd7);

        // async reset during RUN
        issue(3'b001, 32'hFFFFFFFD, 32'd7);
        repeat (5) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("arst busy", 64'(busy), 64'd0);
        check("arst ready", 64'(ready), 64'd1);
        check("arst done", 64'(done), 64'd0);
        check("arst hi", 64'(hi), 64'd0);
        check("arst lo", 64'(lo), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_vec(vecs[11]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit that owns the HI/LO architectural registers for the MIPS150 pipeline.
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO at WIDTH-bit data width.
- Sits beside the ALU in the execute stage. The pipeline issues an op with a start pulse, stalls MFHI/MFLO while busy is high, and reads hi/lo directly.
- Successor to the single-cycle ALU datapath: parametrised width, multi-cycle sequencing, abort (flush) support.

Parameters:
- WIDTH, 32, operand and HI/LO width; must be even and >= 4.
- CNT_W, 6, iteration-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  issue strobe; accepted only on a cycle where ready=1.
- op  in  3  operation: 000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO, 11x reserved.
- a  in  WIDTH  operand A (RS): multiplicand / dividend / MTHI-MTLO source.
- b  in  WIDTH  operand B (RT): multiplier / divisor.
- flush  in  1  abort the in-flight op (pipeline kill).
- ready  out  1  unit idle and able to accept start.
- busy  out  1  multi-cycle op in flight; pipeline stalls MFHI/MFLO while high.
- done  out  1  one-cycle pulse: a MULT/DIV result has just been written to hi/lo.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- State machine: IDLE, RUN, FIX.
- Reset (async, rst=1): state=IDLE, ready=1, busy=0, done=0, hi=0, lo=0, counter=0, working registers=0.
- ready = (state==IDLE). busy = (state!=IDLE). done is registered.
- IDLE + start + op=MTHI: hi<=a at the edge; lo unchanged; state stays IDLE; no done pulse.
- IDLE + start + op=MTLO: lo<=a at the edge; hi unchanged; state stays IDLE; no done pulse.
- IDLE + start + reserved op: ignored; no state change.
- IDLE + start + MULT/MULTU/DIV/DIVU (edge E0):
  - Latch operands as magnitudes (absolute value when signed) and latch the sign flags.
  - Counter<=WIDTH; state<=RUN.
- RUN: one iteration per cycle, counter decrements each cycle; after WIDTH iterations (counter reaches 0), state<=FIX.
  - Multiply: shift-add, 1 bit per cycle, into a 2*WIDTH accumulator.
  - Divide: restoring division, 1 quotient bit per cycle.
- FIX (one cycle): apply signs, then at the edge leaving FIX: write hi/lo, state<=IDLE, done<=1 for exactly one cycle.
  - MULT: negate the 2*WIDTH product if the operand signs differ.
  - DIV: quotient negative if signs differ; remainder takes the dividend's sign.
- Latency: start sampled at edge E0 -> hi/lo valid and done=1 after edge E0+WIDTH+2. busy is high for WIDTH+2 cycles.
- Result placement: MULT/MULTU: hi=product[2W-1:W], lo=product[W-1:0]. DIV/DIVU: lo=quotient, hi=remainder.
- Divide by zero (b=0), checked at start:
  - Still runs full latency (deterministic timing).
  - Result: lo=all ones, hi=a (signed and unsigned alike).
- Signed overflow (DIV, a=-2^(W-1), b=-1): lo=-2^(W-1), hi=0; no trap.
- start while busy: ignored (ready=0); the in-flight op is unaffected; the pipeline must hold the op until ready.
- flush=1 while busy: state<=IDLE next edge; hi/lo unchanged; no done pulse.
- flush=1 while IDLE: no effect.
- flush and start asserted in the same IDLE cycle: flush wins; start ignored.
- rst mid-operation: immediate abort; hi/lo cleared to 0.
- hi/lo hold their values during RUN/FIX; they change only at MTHI/MTLO or at FIX completion.

Test Plan:
- Reset then MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> busy high 34 cycles, done pulse, hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=-3 (0xFFFFFFFD), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=100, full latency. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI a=0x12345678 then MTLO a=0x9ABCDEF0 -> each updates the next cycle, no done, busy stays 0.
- Start DIVU 50/7, assert flush at cycle 10 -> busy drops the next cycle, no done, hi/lo keep prior values. A second start asserted mid-op (before the flush) is ignored: the original result arrives if no flush is given.
- Assert rst during RUN of MULT -> all outputs return to reset values immediately; the next MULTU 6x7 gives lo=42, hi=0.
